// File: rtl/adc_buf_pkg.sv
// Shared definitions for the ADC sample buffer (capture writer and read-back side).
// Holds the reader FSM encoding and the default buffer geometry.
package adc_buf_pkg;

    localparam int NUM_SAMPLES_DEF = 591;
    localparam int ADDR_W_DEF      = 12;
    localparam int DATA_W_DEF      = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/adc_buf_reader_skid.sv
// Two-entry FIFO between the buffer read return and the output stream.
// Entries are pushed one cycle after a read issues and popped on a stream handshake.
module rd_skid_buf #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] r_mem [0:1];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    // Storage is cleared on reset so the stream fields read as zero while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(push) - 2'(pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign valid = (r_count != 2'd0);
    assign count = r_count;

endmodule

// File: rtl/adc_buf_reader.sv
// Reads one frame of ADC samples back from the buffer in address order and streams them
// over valid/ready, reporting per-frame unsigned min/max when the last beat is accepted.
module adc_buf_reader
    import adc_buf_pkg::*;
#(
    parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              adc_clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic [DATA_W-1:0] frame_min,
    output logic [DATA_W-1:0] frame_max,
    output logic              stats_valid,
    output state_t            dbg_state
);

    localparam int                EW        = DATA_W + ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

    state_t            r_state;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_idx;
    logic              r_pend_last;
    logic [DATA_W-1:0] r_run_min;
    logic [DATA_W-1:0] r_run_max;
    logic [DATA_W-1:0] r_frame_min;
    logic [DATA_W-1:0] r_frame_max;
    logic              r_stats_valid;

    logic [EW-1:0]     w_head;
    logic              w_valid;
    logic [1:0]        w_count;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_last_hs;
    logic [DATA_W-1:0] w_head_data;
    logic [ADDR_W-1:0] w_head_idx;
    logic              w_head_last;
    logic              w_seed;
    logic [DATA_W-1:0] w_new_min;
    logic [DATA_W-1:0] w_new_max;

    rd_skid_buf #(.W(EW)) u_skid (
        .clk       (adc_clk),
        .rst       (rst),
        .push      (r_pend),
        .push_data ({buf_rd_data, r_pend_idx, r_pend_last}),
        .pop       (w_pop),
        .head      (w_head),
        .valid     (w_valid),
        .count     (w_count)
    );

    assign w_head_data = w_head[EW-1 -: DATA_W];
    assign w_head_idx  = w_head[ADDR_W:1];
    assign w_head_last = w_head[0];
    assign w_pop       = w_valid & out_ready;
    assign w_last_hs   = w_pop & w_head_last;

    // The beat leaving this cycle frees its slot, which keeps one read per cycle flowing.
    assign w_occ        = 3'(r_pend) + 3'(w_count) - 3'(w_pop);
    assign w_issue      = (r_state == S_FETCH) && (w_occ < 3'd2);
    assign w_issue_last = w_issue && (r_addr == LAST_ADDR);

    // Beat 0 seeds the running extremes instead of comparing against stale values.
    assign w_seed    = (w_head_idx == '0);
    assign w_new_min = (w_seed || (w_head_data < r_run_min)) ? w_head_data : r_run_min;
    assign w_new_max = (w_seed || (w_head_data > r_run_max)) ? w_head_data : r_run_max;

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_addr        <= '0;
            r_pend        <= 1'b0;
            r_pend_idx    <= '0;
            r_pend_last   <= 1'b0;
            r_run_min     <= '1;
            r_run_max     <= '0;
            r_frame_min   <= '1;
            r_frame_max   <= '0;
            r_stats_valid <= 1'b0;
        end else begin
            r_pend        <= w_issue;
            r_pend_idx    <= r_addr;
            r_pend_last   <= w_issue_last;
            r_stats_valid <= w_last_hs;
            if (w_pop) begin
                r_run_min <= w_new_min;
                r_run_max <= w_new_max;
            end
            case (r_state)
                S_IDLE: begin
                    r_addr <= '0;
                    if (start) begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (w_issue_last) begin
                        r_addr  <= '0;
                        r_state <= S_DRAIN;
                    end else if (w_issue) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_last_hs) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_frame_min <= w_new_min;
                        r_frame_max <= w_new_max;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign buf_rd_en   = w_issue;
    assign buf_rd_addr = r_addr;
    assign out_valid   = w_valid;
    assign out_data    = w_head_data;
    assign out_index   = w_head_idx;
    assign out_last    = w_head_last;
    assign frame_min   = r_frame_min;
    assign frame_max   = r_frame_max;
    assign stats_valid = r_stats_valid;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_adc_buf_reader.sv
// Bench for adc_buf_reader: buffer model, scoreboarded stream monitor and directed frame scenarios.
module tb_adc_buf_reader;
    import adc_buf_pkg::*;

    localparam int N  = 591;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int EW = DW + AW + 1;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // main DUT (591 samples)
    logic          start = 1'b0;
    logic          busy, buf_rd_en, out_valid, out_last, stats_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] buf_rd_addr, out_index;
    logic [DW-1:0] buf_rd_data = '0;
    logic [DW-1:0] out_data, frame_min, frame_max;
    state_t        dbg_state;
    logic [DW-1:0] mem [0:N-1];

    adc_buf_reader dut (
        .adc_clk(clk), .rst(rst), .start(start), .busy(busy),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .frame_min(frame_min),
        .frame_max(frame_max), .stats_valid(stats_valid), .dbg_state(dbg_state)
    );

    always @(posedge clk) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

    // single-sample DUT
    logic          s_start = 1'b0;
    logic          s_busy, s_rd_en, s_valid, s_last, s_stats;
    logic [AW-1:0] s_rd_addr, s_index;
    logic [DW-1:0] s_rd_data = '0;
    logic [DW-1:0] s_data, s_min, s_max;
    logic [DW-1:0] s_mem0 = 8'h7F;
    state_t        s_state;

    adc_buf_reader #(.NUM_SAMPLES(1)) dut1 (
        .adc_clk(clk), .rst(rst), .start(s_start), .busy(s_busy),
        .buf_rd_en(s_rd_en), .buf_rd_addr(s_rd_addr), .buf_rd_data(s_rd_data),
        .out_valid(s_valid), .out_ready(1'b1), .out_data(s_data),
        .out_index(s_index), .out_last(s_last), .frame_min(s_min),
        .frame_max(s_max), .stats_valid(s_stats), .dbg_state(s_state)
    );

    always @(posedge clk) if (s_rd_en && s_rd_addr == '0) s_rd_data <= s_mem0;

    // scoreboard
    logic [EW-1:0]   exp_q[$];
    logic [2*DW-1:0] stat_q[$];
    int total = 0;
    int bad = 0;
    int stats_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        logic [DW-1:0] mn;
        logic [DW-1:0] mx;
        logic [AW-1:0] idx;
        mn = 8'hFF;
        mx = 8'h00;
        for (int i = 0; i < N; i++) begin
            idx = i[AW-1:0];
            exp_q.push_back({mem[i], idx, (i == N - 1)});
            if (mem[i] < mn) mn = mem[i];
            if (mem[i] > mx) mx = mem[i];
        end
        stat_q.push_back({mn, mx});
    endtask

    // stimulus knobs
    int rdy_mode = 0;
    bit stall_en = 1'b0;
    bit stalling = 1'b0;
    int stall_cnt = 0;
    int max_rd = 0;
    bit inject_en = 1'b0;

    always @(posedge clk) begin
        #1;
        stalling = 1'b0;
        if (stall_en && out_valid && out_index == 5 && stall_cnt < 20) begin
            out_ready = 1'b0;
            stall_cnt++;
            stalling = 1'b1;
        end else if (rdy_mode == 1) begin
            out_ready = 1'($urandom_range(0, 1));
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(posedge clk) begin
        #2;
        if (inject_en) start = out_valid && (out_index == 100 || (out_last && out_ready));
    end

    // monitor
    bit            held = 1'b0;
    bit            last_seen = 1'b0;
    logic [EW-1:0] held_beat;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
            last_seen = 1'b0;
        end else begin
            if (last_seen) begin
                check("busy_after_last", busy, 0);
                check("stats_after_last", stats_valid, 1);
            end
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_beat", {out_data, out_index, out_last}, held_beat);
            end
            if (stats_valid) begin
                stats_seen++;
                if (stat_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stats_unexpected: got min=%0h max=%0h expected none", frame_min, frame_max);
                end else begin
                    check("frame_minmax", {frame_min, frame_max}, stat_q.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL beat_unexpected: got index=%0d data=%0h expected none", out_index, out_data);
                end else begin
                    check("beat", {out_data, out_index, out_last}, exp_q.pop_front());
                end
            end
            if (stall_en && (stall_cnt < 20 || stalling) && buf_rd_en && int'(buf_rd_addr) > max_rd)
                max_rd = int'(buf_rd_addr);
            last_seen = out_valid && out_ready && out_last;
            held = out_valid && !out_ready;
            held_beat = {out_data, out_index, out_last};
        end
    end

    // driver tasks
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0 || stat_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL frame_timeout: got %0d beats pending expected 0", exp_q.size());
            exp_q.delete();
            stat_q.delete();
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic check_reset();
        check("rst_busy", busy, 0);
        check("rst_rd_en", buf_rd_en, 0);
        check("rst_rd_addr", buf_rd_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_index", out_index, 0);
        check("rst_last", out_last, 0);
        check("rst_min", frame_min, 8'hFF);
        check("rst_max", frame_max, 0);
        check("rst_stats", stats_valid, 0);
        check("rst_state", dbg_state, S_IDLE);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        int n;
        for (int i = 0; i < N; i++) mem[i] = DW'(i % 256);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset();

        // 1: ramp, ready held high, first-beat latency
        s0 = stats_seen;
        push_frame();
        pulse_start();
        @(negedge clk);
        check("lat_busy", busy, 1);
        check("lat_rd_en", buf_rd_en, 1);
        check("lat_rd_addr", buf_rd_addr, 0);
        check("lat_valid_c1", out_valid, 0);
        @(negedge clk);
        check("lat_valid_c2", out_valid, 0);
        @(negedge clk);
        check("lat_valid_c3", out_valid, 1);
        check("lat_index_c3", out_index, 0);
        wait_done(3000);
        check("t1_min", frame_min, 8'h00);
        check("t1_max", frame_max, 8'hFF);
        check("t1_stats", stats_seen - s0, 1);

        // 2: random backpressure
        for (int i = 0; i < N; i++) mem[i] = DW'((i * 37 + 11) % 256);
        rdy_mode = 1;
        push_frame();
        pulse_start();
        wait_done(6000);
        rdy_mode = 0;

        // 3: 20-cycle stall at index 5
        for (int i = 0; i < N; i++) mem[i] = DW'((i * 13 + 200) % 256);
        stall_en = 1'b1;
        stall_cnt = 0;
        max_rd = 0;
        push_frame();
        pulse_start();
        wait_done(3000);
        check("stall_cycles", stall_cnt, 20);
        check("stall_reads_ahead", (max_rd <= 7), 1);
        stall_en = 1'b0;

        // 4: start pulses mid-frame and on the last beat are ignored
        for (int i = 0; i < N; i++) mem[i] = DW'((i * 5 + 90) % 256);
        s0 = stats_seen;
        push_frame();
        pulse_start();
        inject_en = 1'b1;
        wait_done(3000);
        inject_en = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("t4_busy", busy, 0);
        check("t4_state", dbg_state, S_IDLE);
        check("t4_stats", stats_seen - s0, 1);

        // 5: reset mid-frame, then a clean frame
        for (int i = 0; i < N; i++) mem[i] = DW'((i * 29 + 3) % 256);
        push_frame();
        pulse_start();
        n = 0;
        while (n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (out_valid && out_index == 300) break;
        end
        check("t5_reached_300", (n < 3000), 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        stat_q.delete();
        s0 = stats_seen;
        @(negedge clk);
        check_reset();
        repeat (20) @(negedge clk);
        check("t5_no_stats", stats_seen - s0, 0);
        push_frame();
        pulse_start();
        wait_done(3000);

        // 6: single-sample frame
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        n = 0;
        while (!s_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_valid", s_valid, 1);
        check("t6_data", s_data, 8'h7F);
        check("t6_index", s_index, 0);
        check("t6_last", s_last, 1);
        @(negedge clk);
        check("t6_stats", s_stats, 1);
        check("t6_min", s_min, 8'h7F);
        check("t6_max", s_max, 8'h7F);
        check("t6_busy", s_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
